// File: rtl/prog_sequencer_if.sv
// Instruction ROM port and control-unit handshake shared by the sequencer and its neighbours.
// The sequencer drives the master side; ROM and control unit sit on the slave side.
interface prog_sequencer_if;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] inst_out;
    logic        cu_run;
    logic        cu_done;

    modport master (
        output mem_addr,
        output inst_out,
        output cu_run,
        input  mem_rdata,
        input  cu_done
    );

    modport slave (
        input  mem_addr,
        input  inst_out,
        input  cu_run,
        output mem_rdata,
        output cu_done
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches words from a synchronous ROM, issues them to a control unit
// one at a time and waits for completion, with halt-word, end-of-program and timeout stops.
module prog_sequencer #(
    parameter logic [15:0] HALT_INST = 16'hFFFF,
    parameter logic [7:0]  LAST_ADDR = 8'hFF,
    parameter logic [7:0]  TIMEOUT   = 8'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    prog_sequencer_if.master   bus,
    output logic [7:0]         pc,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [15:0]        inst_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t      state_r;
    logic [7:0]  pc_r;
    logic [7:0]  wait_cnt_r;
    logic [15:0] inst_r;
    logic [15:0] count_r;
    logic        run_r;
    logic        busy_r;
    logic        halted_r;
    logic        error_r;
    logic [7:0]  wait_next_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    assign wait_next_s = wait_cnt_r + 8'd1;

    // Sequencer state machine; busy/halted/cu_run are registered alongside each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pc_r       <= 8'd0;
            wait_cnt_r <= 8'd0;
            inst_r     <= 16'd0;
            count_r    <= 16'd0;
            run_r      <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
            error_r    <= 1'b0;
        end else if (abort) begin
            state_r  <= S_IDLE;
            run_r    <= 1'b0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            run_r <= 1'b0;
            case (state_r)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_r  <= S_FETCH;
                        pc_r     <= 8'd0;
                        count_r  <= 16'd0;
                        error_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        halted_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_FETCH: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    // The halt word is never latched, so inst_out keeps the last issued instruction.
                    if (bus.mem_rdata == HALT_INST) begin
                        state_r  <= S_HALT;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else begin
                        inst_r  <= bus.mem_rdata;
                        run_r   <= 1'b1;
                        state_r <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_r <= 8'd0;
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion is checked first so a done arriving on the timeout cycle wins.
                    if (bus.cu_done) begin
                        count_r <= sat_inc16(count_r);
                        if (pc_r == LAST_ADDR) begin
                            state_r  <= S_HALT;
                            busy_r   <= 1'b0;
                            halted_r <= 1'b1;
                        end else begin
                            pc_r    <= pc_r + 8'd1;
                            state_r <= S_FETCH;
                        end
                    end else if (wait_next_s == TIMEOUT) begin
                        wait_cnt_r <= wait_next_s;
                        error_r    <= 1'b1;
                        state_r    <= S_HALT;
                        busy_r     <= 1'b0;
                        halted_r   <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_next_s;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr = pc_r;
    assign bus.inst_out = inst_r;
    assign bus.cu_run   = run_r;
    assign pc           = pc_r;
    assign busy         = busy_r;
    assign halted       = halted_r;
    assign error        = error_r;
    assign inst_count   = count_r;

endmodule
